// File: rtl/rv_stream_source.sv
// rtl/rv_stream_source.sv - ready/valid strided word generator; optional out_last under RV_SRC_LAST_EN
module rv_stream_source #(
    parameter int DATA_W = 32,
    parameter int LEN_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [DATA_W-1:0] cmd_base,
    input  logic [DATA_W-1:0] cmd_stride,
    input  logic [LEN_W-1:0]  cmd_len,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              busy,
    output logic              done
`ifdef RV_SRC_LAST_EN
    ,
    output logic              out_last
`endif
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t             r_state;
    state_t             w_next_state;
    logic               r_ready_en;
    logic [DATA_W-1:0]  r_data;
    logic [DATA_W-1:0]  r_stride;
    logic [LEN_W-1:0]   r_rem;
    logic               r_done;
    logic               w_cmd_fire;
    logic               w_out_fire;
    logic               w_len_zero;
    logic               w_last_word;
    logic               w_done_next;

    // r_ready_en keeps cmd_ready low through reset and for the release edge itself
    assign cmd_ready   = r_ready_en && (r_state == IDLE);
    assign out_valid   = (r_state == RUN);
    assign busy        = (r_state == RUN);
    assign out_data    = r_data;
    assign done        = r_done;

    assign w_cmd_fire  = cmd_valid && cmd_ready;
    assign w_out_fire  = out_valid && out_ready;
    assign w_len_zero  = (cmd_len == '0);
    assign w_last_word = (r_rem == LEN_W'(1));

`ifdef RV_SRC_LAST_EN
    assign out_last    = busy && w_last_word;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_done_next  = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_cmd_fire) begin
                    if (w_len_zero) begin
                        w_done_next = 1'b1;
                    end else begin
                        w_next_state = RUN;
                    end
                end
            end
            RUN: begin
                if (w_out_fire && w_last_word) begin
                    w_next_state = IDLE;
                    w_done_next  = 1'b1;
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_ready_en <= 1'b0;
            r_data     <= '0;
            r_stride   <= '0;
            r_rem      <= '0;
            r_done     <= 1'b0;
        end else begin
            r_ready_en <= 1'b1;
            r_done     <= w_done_next;
            if (w_cmd_fire && !w_len_zero) begin
                r_data   <= cmd_base;
                r_stride <= cmd_stride;
                r_rem    <= cmd_len;
            end else if (w_out_fire) begin
                // modulo-2^DATA_W advance; carry out is intentionally dropped
                r_data <= r_data + r_stride;
                r_rem  <= r_rem - LEN_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_rv_stream_source.sv
// tb/tb_rv_stream_source.sv - scoreboard bench for rv_stream_source
module tb_rv_stream_source;

    logic        clk;
    logic        rst_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [31:0] cmd_base;
    logic [31:0] cmd_stride;
    logic [15:0] cmd_len;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic        busy;
    logic        done;
`ifdef RV_SRC_LAST_EN
    logic        out_last;
`endif

    int          tests_run;
    int          tests_failed;
    logic [31:0] exp_q[$];

    rv_stream_source #(.DATA_W(32), .LEN_W(16)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_base   (cmd_base),
        .cmd_stride (cmd_stride),
        .cmd_len    (cmd_len),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .busy       (busy),
        .done       (done)
`ifdef RV_SRC_LAST_EN
        ,
        .out_last   (out_last)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Offers a command at a negedge, returns at the negedge after the accepting edge.
    task automatic send_cmd(input logic [31:0] b, input logic [31:0] s,
                            input logic [15:0] l, output bit ok);
        ok         = 1'b0;
        cmd_base   = b;
        cmd_stride = s;
        cmd_len    = l;
        cmd_valid  = 1'b1;
        for (int i = 0; i < 50; i++) begin
            if (cmd_ready) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        @(negedge clk);
        cmd_valid = 1'b0;
        if (ok) begin
            for (int i = 0; i < int'(l); i++) exp_q.push_back(b + s * i);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        tests_run++;
        if (cmd_ready !== 1'b0 || out_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || out_data !== 32'h0) begin
            tests_failed++;
            $display("FAIL reset_hold: rdy=%b vld=%b busy=%b done=%b data=%h, expected 0 0 0 0 0", cmd_ready, out_valid, busy, done, out_data);
        end
        rst_n = 1'b1;
        @(negedge clk);
        tests_run++;
        if (cmd_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_idle: rdy=%b vld=%b busy=%b done=%b, expected 1 0 0 0", cmd_ready, out_valid, busy, done);
        end
    endtask

    task automatic test_basic();
        bit ok;
        logic [31:0] e;
        out_ready = 1'b1;
        send_cmd(32'h10, 32'h4, 16'd4, ok);
        tests_run++;
        if (!ok) begin
            tests_failed++;
            $display("FAIL basic_accept: command not accepted, expected accept");
        end
        for (int i = 0; i < 4; i++) begin
            e = (exp_q.size() != 0) ? exp_q.pop_front() : 32'hDEADBEEF;
            tests_run++;
            if (out_valid !== 1'b1 || out_data !== e || busy !== 1'b1 || done !== 1'b0) begin
                tests_failed++;
                $display("FAIL basic_word%0d: vld=%b data=%h busy=%b done=%b, expected 1 %h 1 0", i, out_valid, out_data, busy, done, e);
            end
`ifdef RV_SRC_LAST_EN
            tests_run++;
            if (out_last !== (i == 3)) begin
                tests_failed++;
                $display("FAIL basic_last%0d: got %b, expected %b", i, out_last, (i == 3));
            end
`endif
            @(negedge clk);
        end
        tests_run++;
        if (done !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 || cmd_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL basic_done: done=%b vld=%b busy=%b rdy=%b, expected 1 0 0 1", done, out_valid, busy, cmd_ready);
        end
        @(negedge clk);
        tests_run++;
        if (done !== 1'b0) begin
            tests_failed++;
            $display("FAIL basic_done_pulse: done=%b, expected 0", done);
        end
    endtask

    task automatic test_backpressure();
        bit ok;
        logic [6:0] pat;
        pat = 7'b1101001;
        out_ready = 1'b1;
        send_cmd(32'h10, 32'h4, 16'd4, ok);
        tests_run++;
        if (!ok) begin
            tests_failed++;
            $display("FAIL bp_accept: command not accepted, expected accept");
        end
        for (int c = 0; c < 7; c++) begin
            out_ready = pat[c];
            tests_run++;
            if (exp_q.size() == 0 || out_valid !== 1'b1 || out_data !== exp_q[0]) begin
                tests_failed++;
                $display("FAIL bp_cycle%0d: vld=%b data=%h, expected 1 %h", c, out_valid, out_data, (exp_q.size() != 0) ? exp_q[0] : 32'h0);
            end
`ifdef RV_SRC_LAST_EN
            tests_run++;
            if (out_last !== (exp_q.size() == 1)) begin
                tests_failed++;
                $display("FAIL bp_last%0d: got %b, expected %b", c, out_last, (exp_q.size() == 1));
            end
`endif
            if (pat[c] && exp_q.size() != 0) void'(exp_q.pop_front());
            @(negedge clk);
        end
        out_ready = 1'b1;
        tests_run++;
        if (done !== 1'b1 || out_valid !== 1'b0 || exp_q.size() != 0) begin
            tests_failed++;
            $display("FAIL bp_done: done=%b vld=%b left=%0d, expected 1 0 0", done, out_valid, exp_q.size());
        end
        @(negedge clk);
    endtask

    task automatic test_wrap_zero();
        bit ok;
        logic [31:0] e;
        out_ready = 1'b1;
        send_cmd(32'hFFFFFFFE, 32'h3, 16'd2, ok);
        for (int i = 0; i < 2; i++) begin
            e = (exp_q.size() != 0) ? exp_q.pop_front() : 32'hDEADBEEF;
            tests_run++;
            if (!ok || out_valid !== 1'b1 || out_data !== e) begin
                tests_failed++;
                $display("FAIL wrap_word%0d: ok=%b vld=%b data=%h, expected 1 1 %h", i, ok, out_valid, out_data, e);
            end
            @(negedge clk);
        end
        tests_run++;
        if (done !== 1'b1 || out_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL wrap_done: done=%b vld=%b, expected 1 0", done, out_valid);
        end
        send_cmd(32'h1234, 32'h1, 16'd0, ok);
        tests_run++;
        if (!ok || done !== 1'b1 || out_valid !== 1'b0 || cmd_ready !== 1'b1 || busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL zero_len: ok=%b done=%b vld=%b rdy=%b busy=%b, expected 1 1 0 1 0", ok, done, out_valid, cmd_ready, busy);
        end
        @(negedge clk);
        tests_run++;
        if (done !== 1'b0 || out_valid !== 1'b0 || cmd_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL zero_len_after: done=%b vld=%b rdy=%b, expected 0 0 1", done, out_valid, cmd_ready);
        end
    endtask

    task automatic test_back_to_back();
        bit ok;
        logic [31:0] e;
        out_ready = 1'b1;
        send_cmd(32'h100, 32'h1, 16'd3, ok);
        cmd_base   = 32'h200;
        cmd_stride = 32'h2;
        cmd_len    = 16'd2;
        cmd_valid  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            e = (exp_q.size() != 0) ? exp_q.pop_front() : 32'hDEADBEEF;
            tests_run++;
            if (!ok || out_valid !== 1'b1 || out_data !== e || cmd_ready !== 1'b0) begin
                tests_failed++;
                $display("FAIL b2b_a%0d: ok=%b vld=%b data=%h rdy=%b, expected 1 1 %h 0", i, ok, out_valid, out_data, cmd_ready, e);
            end
            @(negedge clk);
        end
        tests_run++;
        if (done !== 1'b1 || out_valid !== 1'b0 || cmd_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL b2b_bubble: done=%b vld=%b rdy=%b, expected 1 0 1", done, out_valid, cmd_ready);
        end
        for (int i = 0; i < 2; i++) exp_q.push_back(32'h200 + 32'h2 * i);
        @(negedge clk);
        cmd_valid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            e = (exp_q.size() != 0) ? exp_q.pop_front() : 32'hDEADBEEF;
            tests_run++;
            if (out_valid !== 1'b1 || out_data !== e || done !== 1'b0) begin
                tests_failed++;
                $display("FAIL b2b_b%0d: vld=%b data=%h done=%b, expected 1 %h 0", i, out_valid, out_data, done, e);
            end
            @(negedge clk);
        end
        tests_run++;
        if (done !== 1'b1 || out_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL b2b_done: done=%b vld=%b, expected 1 0", done, out_valid);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        bit ok;
        int words;
        logic [31:0] e;
        out_ready = 1'b1;
        send_cmd(32'h1000, 32'h10, 16'd8, ok);
        for (int i = 0; i < 2; i++) begin
            e = (exp_q.size() != 0) ? exp_q.pop_front() : 32'hDEADBEEF;
            tests_run++;
            if (!ok || out_valid !== 1'b1 || out_data !== e) begin
                tests_failed++;
                $display("FAIL mid_word%0d: ok=%b vld=%b data=%h, expected 1 1 %h", i, ok, out_valid, out_data, e);
            end
            if (i == 0) @(negedge clk);
        end
        rst_n = 1'b0;
        @(negedge clk);
        tests_run++;
        if (out_valid !== 1'b0 || done !== 1'b0 || busy !== 1'b0 || cmd_ready !== 1'b0 || out_data !== 32'h0) begin
            tests_failed++;
            $display("FAIL mid_reset: vld=%b done=%b busy=%b rdy=%b data=%h, expected 0 0 0 0 0", out_valid, done, busy, cmd_ready, out_data);
        end
        exp_q.delete();
        rst_n = 1'b1;
        @(negedge clk);
        tests_run++;
        if (done !== 1'b0 || cmd_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL mid_release: done=%b rdy=%b, expected 0 1", done, cmd_ready);
        end
        send_cmd(32'h55, 32'h7, 16'd1, ok);
        words = 0;
        e = (exp_q.size() != 0) ? exp_q[0] : 32'hDEADBEEF;
        for (int c = 0; c < 6; c++) begin
            if (out_valid === 1'b1) begin
                words++;
                tests_run++;
                if (out_data !== e) begin
                    tests_failed++;
                    $display("FAIL mid_single_data: data=%h, expected %h", out_data, e);
                end
            end
            @(negedge clk);
        end
        tests_run++;
        if (!ok || words != 1) begin
            tests_failed++;
            $display("FAIL mid_single_count: ok=%b words=%0d, expected 1 1", ok, words);
        end
        exp_q.delete();
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        rst_n        = 1'b0;
        cmd_valid    = 1'b0;
        cmd_base     = '0;
        cmd_stride   = '0;
        cmd_len      = '0;
        out_ready    = 1'b0;
        @(negedge clk);
        test_reset();
        test_basic();
        test_backpressure();
        test_wrap_zero();
        test_back_to_back();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/rv_stream_source.md
# rv_stream_source

Ready/valid stream transmitter that drives the producer side of the team's single-stage ready/valid pipeline registers. A command (base, stride, length) is accepted on a small ready/valid command port, and the block emits `length` words `base, base+stride, base+2*stride, …` on its output stream, honouring backpressure word by word. It serves as the traffic source in front of pipeline chains, and as a DMA-style address/data generator feeding downstream consumers.

## Interface
- `DATA_W`, 32, width of stream data, `cmd_base` and `cmd_stride`
- `LEN_W`, 16, width of `cmd_len` and of the internal remaining-word counter

- `clk`  in  1  single clock, all logic on rising edge
- `rst_n`  in  1  reset, synchronous, active-low
- `cmd_valid`  in  1  command offered
- `cmd_ready`  out  1  command accepted when `cmd_valid && cmd_ready`
- `cmd_base`  in  DATA_W  first data word
- `cmd_stride`  in  DATA_W  increment between words
- `cmd_len`  in  LEN_W  number of words to emit (0 allowed)
- `out_valid`  out  1  stream word valid
- `out_ready`  in  1  downstream ready
- `out_data`  out  DATA_W  stream word
- `out_last`  out  1  final word of command (only with `RV_SRC_LAST_EN`)
- `busy`  out  1  high while in RUN
- `done`  out  1  one-cycle pulse after a command completes

## Operation
- FSM states: IDLE, RUN. Reset state is IDLE.
- IDLE: `cmd_ready=1`, `out_valid=0`. On a command handshake with `cmd_len!=0`: latch `data_q=cmd_base`, `stride_q=cmd_stride`, `rem_q=cmd_len`, go to RUN. With `cmd_len==0`: stay in IDLE and pulse `done` on the next cycle. No words are emitted.
- RUN: `cmd_ready=0`, `out_valid=1`, `out_data=data_q`, `busy=1`. On an output handshake (`out_valid && out_ready`): `data_q <= data_q + stride_q` (modulo 2^DATA_W, carry discarded) and `rem_q <= rem_q - 1`. If `rem_q==1` at the handshake, go to IDLE and pulse `done`.
- Protocol rules: once asserted, `out_valid` stays high and `out_data` stays stable until the handshake. `out_valid` never depends combinationally on `out_ready`. Commands offered during RUN are not accepted and must be held by the master.
- `cmd_len` = 2^LEN_W−1 is legal. The counter does not wrap before completion.
- Reset: `cmd_ready` resets to 0 (it is 1 from the first cycle after reset deasserts). `out_valid`, `out_data`, `busy`, `done` and `out_last` reset to 0. Internal registers reset to 0.
- Reset asserted mid-RUN: the stream is abandoned, with no `done` pulse. All outputs take their reset values at the first edge with `rst_n=0`.

## Timing
- Command accepted at edge N → `out_valid=1`, `out_data=cmd_base` from cycle N+1.
- Full throughput: with `out_ready` held high, one word per cycle. A length-L command completes in L cycles after acceptance.
- Last handshake at edge M → `out_valid=0`, `busy=0`, `cmd_ready=1`, `done=1` in cycle M+1. `done=0` in cycle M+2.
- The earliest next command is accepted at edge M+1, so its first word appears in cycle M+2. There is a one-cycle bubble between commands.
- Zero-length command at edge N → `done=1` in cycle N+1, and `cmd_ready` stays 1 throughout.
- `out_ready` low for k cycles stretches the current word by k cycles. Data does not advance.

## Configuration
- `RV_SRC_LAST_EN` defined: `out_last` port exists. `out_last = busy && (rem_q==1)`. It is stable with `out_data` under backpressure.
- Not defined: `out_last` port and its logic are absent. All other behaviour is identical.

## Test plan
- Reset then idle: hold `rst_n=0` for 3 cycles, release → `cmd_ready=1`, `out_valid=0`, `done=0`, `busy=0`.
- Basic burst: base=0x10, stride=4, len=4, `out_ready=1` → words 0x10, 0x14, 0x18, 0x1C on 4 consecutive cycles. `done` pulses once in the cycle after 0x1C. With `RV_SRC_LAST_EN`, `out_last=1` only on 0x1C.
- Backpressure: same command with `out_ready` toggling 1,0,0,1,0,1,1 → same 4-word sequence. `out_data` and `out_valid` are stable on every stalled cycle and no word is duplicated or skipped.
- Wrap and zero length: base=0xFFFFFFFE, stride=3, len=2 → 0xFFFFFFFE, 0x00000001. Then len=0 → no `out_valid`, and `done` pulses the cycle after acceptance.
- Back-to-back and blocked command: `cmd_valid` held high with a second command during RUN → second command is not accepted until the cycle after the first `done`. Its first word follows one idle cycle.
- Reset mid-stream: assert `rst_n=0` after the 2nd of 8 words → `out_valid=0` at the next edge, no `done` pulse. After release, a new len=1 command emits exactly one word.
